// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator plus its run enable.
// The generator drives through master; the framebuffer fetch logic and DAC sit on slave.
interface vga_timing_gen_if #(
   parameter int X_W = 10,
   parameter int Y_W = 10
);
   logic           enable;
   logic           hSync;
   logic           vSync;
   logic           bright;
   logic           clk_25Mhz;
   logic           VGA_SYNC_N;
   logic [X_W-1:0] pix_x;
   logic [Y_W-1:0] pix_y;
   logic           pix_tick;
   logic           line_start;
   logic           frame_start;

   modport master (
      input  enable,
      output hSync, vSync, bright, clk_25Mhz, VGA_SYNC_N,
      output pix_x, pix_y, pix_tick, line_start, frame_start
   );

   modport slave (
      output enable,
      input  hSync, vSync, bright, clk_25Mhz, VGA_SYNC_N,
      input  pix_x, pix_y, pix_tick, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe/clock from clk, sync,
// blanking, coordinates and line/frame pulses, all registered with zero skew.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic           clk,
   input  logic           reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0]   H_VIS    = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0]   V_VIS    = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic             HS_ON    = (HS_POL != 0);
   localparam logic             VS_ON    = (VS_POL != 0);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [X_W-1:0]   h_cnt_q,   h_cnt_d;
   logic [Y_W-1:0]   v_cnt_q,   v_cnt_d;
   logic             first_q,   first_d;
   logic             hsync_q,   hsync_d;
   logic             vsync_q,   vsync_d;
   logic             bright_q,  bright_d;
   logic             pclk_q,    pclk_d;
   logic             tick_q,    tick_d;
   logic             line_q,    line_d;
   logic             frame_q,   frame_d;
   logic [X_W-1:0]   pix_x_q,   pix_x_d;
   logic [Y_W-1:0]   pix_y_q,   pix_y_d;
   logic             wrap;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path can infer a latch.
      wrap      = (div_cnt_q == DIV_LAST);
      div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      first_d   = first_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;
      bright_d  = bright_q;
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      tick_d    = wrap;
      line_d    = 1'b0;
      frame_d   = 1'b0;
      pclk_d    = (div_cnt_d >= DIV_HALF);

      if (wrap) begin
         // The first strobe after a restart presents (0,0) instead of advancing past it.
         if (first_q) begin
            first_d = 1'b0;
         end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
         end else begin
            h_cnt_d = h_cnt_q + 1'b1;
         end

         bright_d = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
         hsync_d  = (h_cnt_d >= HS_START && h_cnt_d < HS_END) ? HS_ON : ~HS_ON;
         vsync_d  = (v_cnt_d >= VS_START && v_cnt_d < VS_END) ? VS_ON : ~VS_ON;
         pix_x_d  = bright_d ? h_cnt_d : '0;
         pix_y_d  = bright_d ? v_cnt_d : '0;
         line_d   = (h_cnt_d == '0);
         frame_d  = (h_cnt_d == '0) && (v_cnt_d == '0);
      end

      // Disabled behaves exactly like reset, so a restart always begins a fresh frame.
      if (!vga.enable) begin
         div_cnt_d = '0;
         h_cnt_d   = '0;
         v_cnt_d   = '0;
         first_d   = 1'b1;
         hsync_d   = ~HS_ON;
         vsync_d   = ~VS_ON;
         bright_d  = 1'b0;
         pclk_d    = 1'b0;
         tick_d    = 1'b0;
         line_d    = 1'b0;
         frame_d   = 1'b0;
         pix_x_d   = '0;
         pix_y_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt_q <= '0;
         h_cnt_q   <= '0;
         v_cnt_q   <= '0;
         first_q   <= 1'b1;
         hsync_q   <= ~HS_ON;
         vsync_q   <= ~VS_ON;
         bright_q  <= 1'b0;
         pclk_q    <= 1'b0;
         tick_q    <= 1'b0;
         line_q    <= 1'b0;
         frame_q   <= 1'b0;
         pix_x_q   <= '0;
         pix_y_q   <= '0;
      end else begin
         // NOTE: non-blocking updates make every flop sample pre-edge values, independent of order.
         div_cnt_q <= div_cnt_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         first_q   <= first_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         bright_q  <= bright_d;
         pclk_q    <= pclk_d;
         tick_q    <= tick_d;
         line_q    <= line_d;
         frame_q   <= frame_d;
         pix_x_q   <= pix_x_d;
         pix_y_q   <= pix_y_d;
      end
   end

   assign vga.hSync       = hsync_q;
   assign vga.vSync       = vsync_q;
   assign vga.bright      = bright_q;
   assign vga.clk_25Mhz   = pclk_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.pix_x       = pix_x_q;
   assign vga.pix_y       = pix_y_q;
   assign vga.pix_tick    = tick_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a tiny raster and a CLK_DIV=4 raster
// run side by side; expected values are hand-computed from the pixel index of each sample.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   int   cyc   = 0;
   int   rel   = 0;
   int   tests = 0;
   int   fails = 0;
   int   bcnt, maxx, maxy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_timing_gen_if #(.X_W(10), .Y_W(10)) a_if ();
   vga_timing_gen_if #(.X_W(4),  .Y_W(3))  b_if ();
   vga_timing_gen_if #(.X_W(4),  .Y_W(3))  c_if ();

   assign a_if.enable = enable;
   assign b_if.enable = enable;
   assign c_if.enable = enable;

   vga_timing_gen u_a (.clk(clk), .reset(reset), .vga(a_if.master));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .CLK_DIV(2), .HS_POL(1), .VS_POL(0), .X_W(4), .Y_W(3)
   ) u_b (.clk(clk), .reset(reset), .vga(b_if.master));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
      .CLK_DIV(4), .HS_POL(0), .VS_POL(0), .X_W(4), .Y_W(3)
   ) u_c (.clk(clk), .reset(reset), .vga(c_if.master));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to #1 after the edge that brings cyc to c.
   task automatic go(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b1;
      #23;
      check("rst_a_hsync",  a_if.hSync, 1);
      check("rst_a_vsync",  a_if.vSync, 1);
      check("rst_a_bright", a_if.bright, 0);
      check("rst_a_pclk",   a_if.clk_25Mhz, 0);
      check("rst_a_tick",   a_if.pix_tick, 0);
      check("rst_a_line",   a_if.line_start, 0);
      check("rst_a_frame",  a_if.frame_start, 0);
      check("rst_a_px",     a_if.pix_x, 0);
      check("rst_a_py",     a_if.pix_y, 0);
      check("rst_b_hsync",  b_if.hSync, 0);

      @(posedge clk);
      #1;
      reset = 1'b1;
      rel   = cyc;

      // First pixel after release
      go(rel + 1);
      check("a_tick_c1",  a_if.pix_tick, 0);
      check("c_pclk_c1",  c_if.clk_25Mhz, 0);
      go(rel + 2);
      check("a_tick_c2",  a_if.pix_tick, 1);
      check("a_frame_c2", a_if.frame_start, 1);
      check("a_line_c2",  a_if.line_start, 1);
      check("a_bright_c2", a_if.bright, 1);
      check("a_px_c2",    a_if.pix_x, 0);
      check("a_py_c2",    a_if.pix_y, 0);
      check("a_pclk_c2",  a_if.clk_25Mhz, 0);
      check("b_frame_c2", b_if.frame_start, 1);
      check("c_pclk_c2",  c_if.clk_25Mhz, 1);
      check("c_tick_c2",  c_if.pix_tick, 0);
      go(rel + 3);
      check("a_tick_c3",  a_if.pix_tick, 0);
      check("a_frame_c3", a_if.frame_start, 0);
      check("a_pclk_c3",  a_if.clk_25Mhz, 1);
      check("c_pclk_c3",  c_if.clk_25Mhz, 1);

      // CLK_DIV=4 pixel clock: rising edge 2 clk after each strobe
      go(rel + 4);
      check("c_tick_c4",  c_if.pix_tick, 1);
      check("c_frame_c4", c_if.frame_start, 1);
      check("c_pclk_c4",  c_if.clk_25Mhz, 0);
      go(rel + 5);
      check("c_pclk_c5",  c_if.clk_25Mhz, 0);
      check("c_tick_c5",  c_if.pix_tick, 0);
      go(rel + 6);
      check("c_pclk_c6",  c_if.clk_25Mhz, 1);
      go(rel + 7);
      check("c_pclk_c7",  c_if.clk_25Mhz, 1);
      go(rel + 8);
      check("c_tick_c8",  c_if.pix_tick, 1);
      check("c_pclk_c8",  c_if.clk_25Mhz, 0);
      check("c_px_c8",    c_if.pix_x, 1);
      check("c_syncn",    c_if.VGA_SYNC_N, 0);

      // Small raster, HS_POL=1: hSync high on h 10..12
      go(rel + 20);
      check("b_hs_h9",  b_if.hSync, 0);
      go(rel + 22);
      check("b_hs_h10", b_if.hSync, 1);
      check("b_bright_h10", b_if.bright, 0);
      go(rel + 26);
      check("b_hs_h12", b_if.hSync, 1);
      go(rel + 28);
      check("b_hs_h13", b_if.hSync, 0);

      // Small raster vSync active on line 5 only
      go(rel + 161);
      check("b_vs_v4", b_if.vSync, 1);
      go(rel + 162);
      check("b_vs_v5", b_if.vSync, 0);
      go(rel + 193);
      check("b_vs_v5_end", b_if.vSync, 0);
      go(rel + 194);
      check("b_vs_v6", b_if.vSync, 1);

      // Last pixel of the frame then the wrap
      go(rel + 256);
      check("b_tick_last",  b_if.pix_tick, 1);
      check("b_frame_last", b_if.frame_start, 0);
      check("b_line_last",  b_if.line_start, 0);
      check("b_bright_last", b_if.bright, 0);
      go(rel + 258);
      check("b_frame_wrap", b_if.frame_start, 1);
      check("b_bright_wrap", b_if.bright, 1);
      check("b_py_wrap",    b_if.pix_y, 0);

      bcnt = 0;
      maxx = 0;
      maxy = 0;
      for (int i = 0; i < 256; i++) begin
         go(rel + 258 + i);
         if (b_if.pix_tick && b_if.bright) bcnt++;
         if (int'(b_if.pix_x) > maxx) maxx = int'(b_if.pix_x);
         if (int'(b_if.pix_y) > maxy) maxy = int'(b_if.pix_y);
      end
      check("b_bright_count", bcnt, 32);
      check("b_max_px", maxx, 7);
      check("b_max_py", maxy, 3);

      // Default horizontal timing
      go(rel + 602);
      check("a_px_300", a_if.pix_x, 300);
      check("a_py_300", a_if.pix_y, 0);
      go(rel + 1281);
      check("a_bright_639", a_if.bright, 1);
      check("a_px_639", a_if.pix_x, 639);
      go(rel + 1282);
      check("a_bright_640", a_if.bright, 0);
      check("a_px_640", a_if.pix_x, 0);
      go(rel + 1313);
      check("a_hs_655", a_if.hSync, 1);
      go(rel + 1314);
      check("a_hs_656", a_if.hSync, 0);
      go(rel + 1505);
      check("a_hs_751", a_if.hSync, 0);
      go(rel + 1506);
      check("a_hs_752", a_if.hSync, 1);
      check("a_vs_line0", a_if.vSync, 1);
      go(rel + 1602);
      check("a_line_1600", a_if.line_start, 1);
      check("a_frame_1600", a_if.frame_start, 0);
      check("a_py_line1", a_if.pix_y, 1);
      check("a_px_line1", a_if.pix_x, 0);
      go(rel + 1603);
      check("a_line_pulse", a_if.line_start, 0);

      // enable low for 3 clk mid-frame
      go(rel + 1613);
      check("b_px_pre_dis", b_if.pix_x, 5);
      check("b_py_pre_dis", b_if.pix_y, 2);
      enable = 1'b0;
      go(rel + 1614);
      check("b_px_dis",     b_if.pix_x, 0);
      check("b_bright_dis", b_if.bright, 0);
      check("b_hs_dis",     b_if.hSync, 0);
      check("a_bright_dis", a_if.bright, 0);
      go(rel + 1616);
      check("a_hs_dis",     a_if.hSync, 1);
      check("a_tick_dis",   a_if.pix_tick, 0);
      enable = 1'b1;
      go(rel + 1617);
      check("a_frame_en1", a_if.frame_start, 0);
      go(rel + 1618);
      check("a_frame_en2", a_if.frame_start, 1);
      check("a_line_en2",  a_if.line_start, 1);
      check("b_frame_en2", b_if.frame_start, 1);
      check("b_px_en2",    b_if.pix_x, 0);
      check("b_bright_en2", b_if.bright, 1);
      go(rel + 1619);
      check("c_frame_en3", c_if.frame_start, 0);
      go(rel + 1620);
      check("c_frame_en4", c_if.frame_start, 1);

      // Asynchronous reset mid-line, observed before any clock edge
      go(rel + 1630);
      check("a_px_pre_rst", a_if.pix_x, 6);
      reset = 1'b0;
      #2;
      check("a_px_rst",     a_if.pix_x, 0);
      check("a_bright_rst", a_if.bright, 0);
      check("a_hs_rst",     a_if.hSync, 1);
      check("b_hs_rst",     b_if.hSync, 0);
      check("b_tick_rst",   b_if.pix_tick, 0);
      check("a_syncn",      a_if.VGA_SYNC_N, 0);
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
